// File: rtl/scpu_pkg.sv
// Shared SCPU constants: the idle value for ext_in and the IN/OUT opcodes
// that the CPU top level decodes to produce in_ack / out_stb.
package scpu_pkg;

   localparam logic [7:0] EMPTY_VALUE_DEF = 8'h00;
   localparam logic [3:0] OP_IN           = 4'hE;
   localparam logic [3:0] OP_OUT          = 4'hF;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/scpu_io_port_if.sv
// Host/CPU byte bus seen by scpu_io_port; slave is the port itself,
// master is whoever drives the host and CPU sides.
interface scpu_io_port_if #(
   parameter int DEPTH = 4
) ();
   logic [7:0]              host_in_data;
   logic                    host_in_valid;
   logic                    host_in_ready;
   logic [7:0]              ext_in;
   logic                    in_avail;
   logic                    in_ack;
   logic [7:0]              ext_out;
   logic                    out_stb;
   logic [7:0]              host_out_data;
   logic                    host_out_valid;
   logic                    host_out_ready;
   logic [$clog2(DEPTH):0]  in_count;
   logic [$clog2(DEPTH):0]  out_count;
   logic                    in_underflow;
   logic                    out_overflow;
   logic                    clr_flags;

   modport slave (
      input  host_in_data, host_in_valid, in_ack, ext_out, out_stb,
             host_out_ready, clr_flags,
      output host_in_ready, ext_in, in_avail, host_out_data, host_out_valid,
             in_count, out_count, in_underflow, out_overflow
   );

   modport master (
      output host_in_data, host_in_valid, in_ack, ext_out, out_stb,
             host_out_ready, clr_flags,
      input  host_in_ready, ext_in, in_avail, host_out_data, host_out_valid,
             in_count, out_count, in_underflow, out_overflow
   );
endinterface

// File: rtl/scpu_byte_fifo.sv
// Show-ahead byte FIFO with a registered head: dout holds its last value
// when the FIFO empties, so stale storage is never exposed.
module scpu_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [7:0]              din,
   output logic [7:0]              dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    head_q, head_d;
   logic          push_ok, pop_ok;

   // A push into a full FIFO is legal only when a pop frees the slot the same cycle.
   always_comb begin
      pop_ok  = pop & (cnt_q != '0);
      push_ok = push & ((cnt_q != FULL_CNT) | pop_ok);
      rd_d    = pop_ok  ? rd_q + 1'b1 : rd_q;
      wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
      cnt_d   = cnt_q;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      head_d = head_q;
      if (cnt_d != '0)
         head_d = (push_ok && (wr_q == rd_d)) ? din : mem_q[rd_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         head_q <= 8'h00;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_q] <= din;
   end

   assign dout  = head_q;
   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/scpu_io_port.sv
// Host-side endpoint of the SCPU byte interface: input FIFO feeding ext_in,
// output FIFO collecting OUT bytes, plus sticky underflow/overflow flags.
module scpu_io_port
   import scpu_pkg::*;
#(
   parameter int         DEPTH       = 4,
   parameter logic [7:0] EMPTY_VALUE = EMPTY_VALUE_DEF
) (
   input  logic           clk,
   input  logic           rst,
   scpu_io_port_if.slave  bus
);
   logic [7:0]             in_head, out_head;
   logic                   in_full, in_empty, out_full, out_empty;
   logic [$clog2(DEPTH):0] in_cnt, out_cnt;
   logic                   in_push, out_pop;
   logic                   in_uf_q, in_uf_d, out_of_q, out_of_d;

   // Host pushes only against !full; a same-cycle in_ack does not make room.
   assign in_push = bus.host_in_valid & ~in_full;
   assign out_pop = bus.host_out_ready & ~out_empty;

   scpu_byte_fifo #(.DEPTH(DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_push),
      .pop   (bus.in_ack),
      .din   (bus.host_in_data),
      .dout  (in_head),
      .full  (in_full),
      .empty (in_empty),
      .count (in_cnt)
   );

   scpu_byte_fifo #(.DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.out_stb),
      .pop   (out_pop),
      .din   (bus.ext_out),
      .dout  (out_head),
      .full  (out_full),
      .empty (out_empty),
      .count (out_cnt)
   );

   // Setting a flag wins over clearing it in the same cycle.
   always_comb begin
      in_uf_d  = (bus.in_ack & in_empty) | (in_uf_q & ~bus.clr_flags);
      out_of_d = (bus.out_stb & out_full & ~out_pop) | (out_of_q & ~bus.clr_flags);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_uf_q  <= 1'b0;
         out_of_q <= 1'b0;
      end else begin
         in_uf_q  <= in_uf_d;
         out_of_q <= out_of_d;
      end
   end

   assign bus.host_in_ready  = ~in_full;
   assign bus.ext_in         = in_empty ? EMPTY_VALUE : in_head;
   assign bus.in_avail       = ~in_empty;
   assign bus.host_out_data  = out_head;
   assign bus.host_out_valid = ~out_empty;
   assign bus.in_count       = in_cnt;
   assign bus.out_count      = out_cnt;
   assign bus.in_underflow   = in_uf_q;
   assign bus.out_overflow   = out_of_q;

endmodule

// File: tb/tb_scpu_io_port.sv
// Bench for scpu_io_port: directed scenarios then random traffic, all checked
// against a queue-based reference model of the two FIFOs and sticky flags.
module tb_scpu_io_port;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scpu_io_port_if #(.DEPTH(DEPTH)) bus ();

   scpu_io_port #(.DEPTH(DEPTH), .EMPTY_VALUE(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [7:0] inq[$];
   logic [7:0] outq[$];
   logic [7:0] last_out;
   bit         uf, ovf;
   int         total = 0;
   int         bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, "_host_in_ready"}, 32'(bus.host_in_ready), 32'(inq.size() < DEPTH));
      chk({ph, "_ext_in"}, 32'(bus.ext_in), (inq.size() > 0) ? 32'(inq[0]) : 32'h00);
      chk({ph, "_in_avail"}, 32'(bus.in_avail), 32'(inq.size() > 0));
      chk({ph, "_in_count"}, 32'(bus.in_count), 32'(inq.size()));
      chk({ph, "_host_out_valid"}, 32'(bus.host_out_valid), 32'(outq.size() > 0));
      chk({ph, "_host_out_data"}, 32'(bus.host_out_data), 32'(last_out));
      chk({ph, "_out_count"}, 32'(bus.out_count), 32'(outq.size()));
      chk({ph, "_in_underflow"}, 32'(bus.in_underflow), 32'(uf));
      chk({ph, "_out_overflow"}, 32'(bus.out_overflow), 32'(ovf));
   endtask

   // One clock: drive inputs, advance the model on the edge, check #1 later.
   task automatic step(input string ph, input logic hv, input logic [7:0] hd,
                       input logic ack, input logic [7:0] eo, input logic stb,
                       input logic hr, input logic clr, input logic r);
      bit in_pop, in_push, out_pop, out_push, uf_set, of_set;
      rst                = r;
      bus.host_in_valid  = hv;
      bus.host_in_data   = hd;
      bus.in_ack         = ack;
      bus.ext_out        = eo;
      bus.out_stb        = stb;
      bus.host_out_ready = hr;
      bus.clr_flags      = clr;
      @(posedge clk);
      if (r) begin
         inq.delete();
         outq.delete();
         last_out = 8'h00;
         uf  = 0;
         ovf = 0;
      end else begin
         in_pop   = ack && inq.size() > 0;
         in_push  = hv && inq.size() < DEPTH;
         uf_set   = ack && inq.size() == 0;
         out_pop  = hr && outq.size() > 0;
         out_push = stb && (outq.size() < DEPTH || out_pop);
         of_set   = stb && outq.size() == DEPTH && !out_pop;
         if (in_pop) void'(inq.pop_front());
         if (in_push) inq.push_back(hd);
         if (out_pop) void'(outq.pop_front());
         if (out_push) outq.push_back(eo);
         if (outq.size() > 0) last_out = outq[0];
         uf  = uf_set || (uf && !clr);
         ovf = of_set || (ovf && !clr);
      end
      #1;
      check_all(ph);
   endtask

   task automatic idle(input string ph);
      step(ph, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
   endtask

   initial begin
      last_out = 8'h00;
      uf  = 0;
      ovf = 0;

      // Reset state
      step("rst0", 0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
      step("rst1", 1, 8'h77, 0, 8'h66, 1, 0, 0, 1);
      chk("rst_ext_in", 32'(bus.ext_in), 32'h00);
      chk("rst_host_in_ready", 32'(bus.host_in_ready), 32'h1);

      // 1: three pushes, then in_ack walks the head
      step("t1p", 1, 8'h11, 0, 8'h00, 0, 0, 0, 0);
      step("t1p", 1, 8'h22, 0, 8'h00, 0, 0, 0, 0);
      step("t1p", 1, 8'h33, 0, 8'h00, 0, 0, 0, 0);
      chk("t1_in_count", 32'(bus.in_count), 32'd3);
      chk("t1_ext_in_11", 32'(bus.ext_in), 32'h11);
      step("t1a", 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
      chk("t1_ext_in_22", 32'(bus.ext_in), 32'h22);
      step("t1a", 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
      chk("t1_ext_in_33", 32'(bus.ext_in), 32'h33);
      step("t1a", 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
      chk("t1_ext_in_empty", 32'(bus.ext_in), 32'h00);
      chk("t1_in_avail", 32'(bus.in_avail), 32'h0);

      // 2: five pushes with valid held; fifth waits for an in_ack
      for (int i = 0; i < 4; i++) step("t2p", 1, 8'(8'h41 + i), 0, 8'h00, 0, 0, 0, 0);
      chk("t2_ready_low", 32'(bus.host_in_ready), 32'h0);
      step("t2hold", 1, 8'h45, 0, 8'h00, 0, 0, 0, 0);
      chk("t2_count_sat", 32'(bus.in_count), 32'd4);
      step("t2ack", 1, 8'h45, 1, 8'h00, 0, 0, 0, 0);
      chk("t2_count_after_ack", 32'(bus.in_count), 32'd3);
      step("t2push5", 1, 8'h45, 0, 8'h00, 0, 0, 0, 0);
      chk("t2_head_42", 32'(bus.ext_in), 32'h42);
      for (int i = 0; i < 4; i++) step("t2drain", 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
      chk("t2_drained", 32'(bus.in_count), 32'd0);

      // 3: single OUT byte, held until ready
      step("t3stb", 0, 8'h00, 0, 8'hA5, 1, 0, 0, 0);
      chk("t3_valid", 32'(bus.host_out_valid), 32'h1);
      chk("t3_data", 32'(bus.host_out_data), 32'hA5);
      idle("t3hold");
      step("t3pop", 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
      chk("t3_popped", 32'(bus.host_out_valid), 32'h0);

      // 4: overflow on full without pop, accepted with pop
      for (int i = 0; i < 4; i++) step("t4f", 0, 8'h00, 0, 8'(8'hB0 + i), 1, 0, 0, 0);
      step("t4ovf", 0, 8'h00, 0, 8'hBF, 1, 0, 0, 0);
      chk("t4_overflow", 32'(bus.out_overflow), 32'h1);
      chk("t4_count", 32'(bus.out_count), 32'd4);
      step("t4clr", 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
      step("t4pp", 0, 8'h00, 0, 8'hB4, 1, 1, 0, 0);
      chk("t4_no_flag", 32'(bus.out_overflow), 32'h0);
      chk("t4_head_b1", 32'(bus.host_out_data), 32'hB1);
      for (int i = 0; i < 4; i++) step("t4drain", 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
      chk("t4_last_b4", 32'(bus.host_out_data), 32'hB4);

      // 5: underflow and flag clear priority
      step("t5uf", 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
      chk("t5_underflow", 32'(bus.in_underflow), 32'h1);
      step("t5clr", 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
      chk("t5_cleared", 32'(bus.in_underflow), 32'h0);
      step("t5uf2", 0, 8'h00, 1, 8'h00, 0, 0, 0, 0);
      step("t5both", 0, 8'h00, 1, 8'h00, 0, 0, 1, 0);
      chk("t5_set_wins", 32'(bus.in_underflow), 32'h1);
      step("t5pushpop", 1, 8'h5C, 1, 8'h00, 0, 0, 0, 0);
      chk("t5_push_lands", 32'(bus.ext_in), 32'h5C);

      // 6: reset with both FIFOs partly full
      step("t6a", 1, 8'h61, 0, 8'hC1, 1, 0, 0, 0);
      step("t6b", 0, 8'h00, 0, 8'hC2, 1, 0, 0, 0);
      step("t6rst", 1, 8'h62, 0, 8'hC3, 1, 0, 0, 1);
      chk("t6_in_count", 32'(bus.in_count), 32'd0);
      chk("t6_out_valid", 32'(bus.host_out_valid), 32'h0);
      chk("t6_underflow", 32'(bus.in_underflow), 32'h0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         step("rnd",
              1'($urandom_range(0, 99) < 55), 8'($urandom),
              1'($urandom_range(0, 99) < 45), 8'($urandom),
              1'($urandom_range(0, 99) < 50),
              1'($urandom_range(0, 99) < 40),
              1'($urandom_range(0, 99) < 8),
              1'($urandom_range(0, 199) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
